gpu_blit: RTL and testbench
===========================

Name: gpu_blit

Overview:
- Sprite blitter for the CHIP-8 core; parametrised successor of the byte-aligned sprite drawer.
- On a `draw` pulse, XORs an N-line, 8-pixel-wide sprite into the screen buffer in shared memory at any pixel (x, y).
- Handles sub-byte horizontal shift, so one sprite row can straddle two screen bytes.
- Supports per-draw wrap or clip at the screen edges and reports the CHIP-8 VF collision flag.
- Shares the CPU's single-port memory through the existing read-with-ack / single-cycle-write interface.

Parameters:
- ADDR_W, 12, memory address width.
- SCREEN_BASE, 12'h100, address of the screen byte for pixel (0, 0).
- W_BYTES, 8, screen width in bytes (64 px). Must be a power of 2, at least 2.
- SCREEN_H, 32, screen height in rows. Must be a power of 2.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- draw  in  1  start pulse; accepted only when idle.
- wrap  in  1  sampled on accept. 1 = wrap at the edges, 0 = clip at the edges.
- addr  in  ADDR_W  address of the first sprite byte.
- lines  in  4  number of sprite rows (0..15).
- x  in  8  pixel column.
- y  in  8  pixel row.
- busy  out  1  high while a draw is in progress.
- collision  out  1  at least one set pixel was cleared by the last completed draw.
- mem_read  out  1  read request.
- mem_read_idx  out  ADDR_W  read address.
- mem_read_byte  in  8  read data, valid when mem_read_ack is high.
- mem_read_ack  in  1  one-cycle pulse completing a read.
- mem_write  out  1  write strobe; a write completes in one cycle.
- mem_write_idx  out  ADDR_W  write address.
- mem_write_byte  out  8  write data.

Behaviour:
- Reset (rst_n=0 at posedge): state goes to IDLE, collision=0, busy=0. All mem_* outputs are 0 in the same cycle, since they decode combinationally from state. Reset mid-draw abandons the draw; no further writes occur.
- Accept: in IDLE with draw=1, the block latches the following:
  - sprite pointer = addr;
  - remaining rows = lines;
  - px = x mod (W_BYTES*8);
  - row = y mod SCREEN_H;
  - wrap mode;
  - collision cleared to 0.
- If lines=0 the block stays in IDLE. No memory access occurs and collision reads 0.
- draw while busy is ignored.
- Derived per draw:
  - cx = px>>3, sh = px[2:0];
  - {L, R} = {sprite_byte, 8'h00} >> sh (16-bit shift);
  - row address = SCREEN_BASE + row*W_BYTES (shift, no multiplier).
- States: IDLE, LOAD_SPRITE, LOAD_L, STORE_L, LOAD_R, STORE_R.
  - LOAD_SPRITE: request the read at the sprite pointer. On ack, latch L/R and go to LOAD_L.
  - LOAD_L: read row address + cx. On ack: latched byte = scr ^ L; collision |= |(scr & L|); go to STORE_L.
  - STORE_L: write the latched byte at row address + cx. Then:
    - if sh=0, go to the next-row step;
    - if sh≠0 and wrap=0 and cx = W_BYTES-1, the R byte is clipped; go to the next-row step;
    - otherwise go to LOAD_R.
  - LOAD_R / STORE_R: same as the L pair on column (cx+1) mod W_BYTES, using R.
- Next-row step:
  - if remaining = 1, go to IDLE;
  - else if wrap=0 and row = SCREEN_H-1, go to IDLE (clip);
  - else decrement remaining, increment the sprite pointer, row = (row+1) mod SCREEN_H, go to LOAD_SPRITE.
- Memory handshake:
  - In a load state, mem_read=1 with its address while mem_read_ack=0. It is dropped in the ack cycle.
  - mem_read and mem_write are never high together. Both are 0 in IDLE.
  - Outputs not in use drive 0.
- Latency with a next-cycle ack: each load takes 2 cycles and each store 1 cycle.
  - A row costs 5 cycles when sh=0 or R is clipped, otherwise 8.
  - busy rises the cycle after accept and falls when the last store retires.
- collision is registered; it is updated during the draw and holds until the next accepted draw.
- Sprite address arithmetic wraps modulo 2^ADDR_W.

Decomposition:
- Package gpu_pkg holds:
  - the state encoding;
  - the SCREEN_BASE / W_BYTES / SCREEN_H defaults, shared with the display scanout;
  - a function giving the screen byte address for (row, col).
- Sub-module sprite_shifter (combinational, byte + 3-bit shift to {L, R}) is natural so that scanout and tests can reuse it. Everything else stays in gpu_blit.

Test Plan (W_BYTES=8, SCREEN_H=32, base 0x100, memory model acks the next cycle, screen initially zero):
- x=0, y=0, lines=1, mem[0x200]=0xF0 -> one write, 0x100=0xF0; collision=0; busy high for 5 cycles.
- x=4, y=1, lines=1, mem[0x200]=0xFF -> 0x108=0x0F, then 0x109=0xF0; busy high for 8 cycles.
- x=60, y=0, 0xFF, wrap=1 -> 0x107=0x0F and 0x100=0xF0. With wrap=0 -> only 0x107 is written.
- y=31, lines=2, x=0, wrap=1 -> writes to 0x1F8 then 0x100. With wrap=0 -> 0x1F8 only, and busy drops after one row.
- Repeat the first scenario twice -> second draw gives 0x100=0x00 and collision=1. A third draw with lines=0 -> collision=0, no memory traffic.
- Assert rst_n=0 during LOAD_R, plus x=200 on the next draw (=8 mod 64) -> after reset: busy=0, no write; the next draw targets cx=1 (0x101).

Source files
------------

// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - shared definitions for the CHIP-8 sprite blitter and display scanout
//
// Holds the blitter state encoding, the default screen geometry shared with the
// scanout, and the screen byte address helper.
package gpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_LOAD_SPRITE = 3'd1,
        ST_LOAD_L      = 3'd2,
        ST_STORE_L     = 3'd3,
        ST_LOAD_R      = 3'd4,
        ST_STORE_R     = 3'd5
    } blit_state_e;

    localparam int unsigned GPU_SCREEN_BASE = 32'h100;
    localparam int unsigned GPU_W_BYTES     = 8;
    localparam int unsigned GPU_SCREEN_H    = 32;

    // Byte address of screen column byte col on row row. The screen width is a
    // power of two, so the row stride is a shift rather than a multiply.
    function automatic logic [31:0] screen_byte_addr(
        input logic [31:0] base,
        input logic [31:0] row,
        input logic [31:0] col,
        input int unsigned wb_log2
    );
        return base + (row << wb_log2) + col;
    endfunction

endpackage

// File: rtl/sprite_shifter.sv
// rtl/sprite_shifter.sv - splits one sprite byte across two screen bytes
//
// Ports:
//   byte_in  sprite row, MSB is the leftmost pixel
//   sh       pixel offset within the first screen byte (0..7)
//   l_out    part of the sprite landing in the left screen byte
//   r_out    part spilling into the right screen byte (0 when sh = 0)
module sprite_shifter (
    input  logic [7:0] byte_in,
    input  logic [2:0] sh,
    output logic [7:0] l_out,
    output logic [7:0] r_out
);

    logic [15:0] wide;

    assign wide  = {byte_in, 8'h00} >> sh;
    assign l_out = wide[15:8];
    assign r_out = wide[7:0];

endmodule

// File: rtl/gpu_blit.sv
// rtl/gpu_blit.sv - CHIP-8 sprite blitter with sub-byte shift, wrap/clip and collision
//
// XORs an N-row, 8-pixel-wide sprite into the screen buffer held in the CPU's
// single-port memory, one read-modify-write per touched screen byte.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   draw, wrap, addr, lines, x, y   draw request and its parameters (sampled when idle)
//   busy                            draw in progress
//   collision                       last completed draw cleared at least one set pixel
//   mem_read, mem_read_idx          read request and address
//   mem_read_byte, mem_read_ack     read data and one-cycle completion pulse
//   mem_write, mem_write_idx,
//   mem_write_byte                  single-cycle write strobe, address and data
module gpu_blit
    import gpu_pkg::*;
#(
    parameter int          ADDR_W      = 12,
    parameter int unsigned SCREEN_BASE = GPU_SCREEN_BASE,
    parameter int unsigned W_BYTES     = GPU_W_BYTES,
    parameter int unsigned SCREEN_H    = GPU_SCREEN_H
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              draw,
    input  logic              wrap,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        lines,
    input  logic [7:0]        x,
    input  logic [7:0]        y,
    output logic              busy,
    output logic              collision,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_read_idx,
    input  logic [7:0]        mem_read_byte,
    input  logic              mem_read_ack,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_write_idx,
    output logic [7:0]        mem_write_byte
);

    localparam int PX_W  = $clog2(W_BYTES * 8);
    localparam int CX_W  = $clog2(W_BYTES);
    localparam int ROW_W = (SCREEN_H > 1) ? $clog2(SCREEN_H) : 1;

    blit_state_e       state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [3:0]        rem_q, rem_d;
    logic [PX_W-1:0]   px_q, px_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic              wrap_q, wrap_d;
    logic              coll_q, coll_d;
    logic              busy_q, busy_d;
    logic [7:0]        l_q, l_d;
    logic [7:0]        r_q, r_d;
    logic [7:0]        data_q, data_d;

    logic [CX_W-1:0]   cx;
    logic [CX_W-1:0]   cx_r;
    logic [2:0]        sh;
    logic [ADDR_W-1:0] addr_l;
    logic [ADDR_W-1:0] addr_r;
    logic [7:0]        shift_l;
    logic [7:0]        shift_r;
    logic              row_done;
    logic              last_row;

    assign cx   = px_q[PX_W-1:3];
    assign sh   = px_q[2:0];
    // Right column wraps naturally in CX_W bits; clipping is decided in STORE_L.
    assign cx_r = cx + CX_W'(1);

    assign addr_l = ADDR_W'(screen_byte_addr(32'(SCREEN_BASE), 32'(row_q), 32'(cx), CX_W));
    assign addr_r = ADDR_W'(screen_byte_addr(32'(SCREEN_BASE), 32'(row_q), 32'(cx_r), CX_W));

    // A row is the last one if the count runs out or clipping hits the bottom edge.
    assign last_row = (rem_q == 4'd1) || (!wrap_q && (&row_q));

    sprite_shifter u_shifter (
        .byte_in (mem_read_byte),
        .sh      (sh),
        .l_out   (shift_l),
        .r_out   (shift_r)
    );

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        rem_d          = rem_q;
        px_d           = px_q;
        row_d          = row_q;
        wrap_d         = wrap_q;
        coll_d         = coll_q;
        l_d            = l_q;
        r_d            = r_q;
        data_d         = data_q;
        row_done       = 1'b0;
        mem_read       = 1'b0;
        mem_read_idx   = '0;
        mem_write      = 1'b0;
        mem_write_idx  = '0;
        mem_write_byte = 8'h00;

        case (state_q)
            ST_IDLE: begin
                if (draw) begin
                    ptr_d  = addr;
                    rem_d  = lines;
                    px_d   = PX_W'(x);
                    row_d  = ROW_W'(y);
                    wrap_d = wrap;
                    coll_d = 1'b0;
                    if (lines != 4'd0) begin
                        state_d = ST_LOAD_SPRITE;
                    end
                end
            end

            ST_LOAD_SPRITE: begin
                if (mem_read_ack) begin
                    l_d     = shift_l;
                    r_d     = shift_r;
                    state_d = ST_LOAD_L;
                end else begin
                    mem_read     = 1'b1;
                    mem_read_idx = ptr_q;
                end
            end

            ST_LOAD_L: begin
                if (mem_read_ack) begin
                    data_d  = mem_read_byte ^ l_q;
                    coll_d  = coll_q | (|(mem_read_byte & l_q));
                    state_d = ST_STORE_L;
                end else begin
                    mem_read     = 1'b1;
                    mem_read_idx = addr_l;
                end
            end

            ST_STORE_L: begin
                mem_write      = 1'b1;
                mem_write_idx  = addr_l;
                mem_write_byte = data_q;
                if ((sh == 3'd0) || (!wrap_q && (&cx))) begin
                    row_done = 1'b1;
                end else begin
                    state_d = ST_LOAD_R;
                end
            end

            ST_LOAD_R: begin
                if (mem_read_ack) begin
                    data_d  = mem_read_byte ^ r_q;
                    coll_d  = coll_q | (|(mem_read_byte & r_q));
                    state_d = ST_STORE_R;
                end else begin
                    mem_read     = 1'b1;
                    mem_read_idx = addr_r;
                end
            end

            ST_STORE_R: begin
                mem_write      = 1'b1;
                mem_write_idx  = addr_r;
                mem_write_byte = data_q;
                row_done       = 1'b1;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (row_done) begin
            if (last_row) begin
                state_d = ST_IDLE;
            end else begin
                rem_d   = rem_q - 4'd1;
                ptr_d   = ptr_q + ADDR_W'(1);
                row_d   = row_q + ROW_W'(1);
                state_d = ST_LOAD_SPRITE;
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            rem_q   <= 4'd0;
            px_q    <= '0;
            row_q   <= '0;
            wrap_q  <= 1'b0;
            coll_q  <= 1'b0;
            busy_q  <= 1'b0;
            l_q     <= 8'h00;
            r_q     <= 8'h00;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            px_q    <= px_d;
            row_q   <= row_d;
            wrap_q  <= wrap_d;
            coll_q  <= coll_d;
            busy_q  <= busy_d;
            l_q     <= l_d;
            r_q     <= r_d;
            data_q  <= data_d;
        end
    end

    assign busy      = busy_q;
    assign collision = coll_q;

endmodule

// File: tb/tb_gpu_blit.sv
// tb/tb_gpu_blit.sv - directed self-checking bench for gpu_blit
module tb_gpu_blit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        draw = 1'b0;
    logic        wrap = 1'b0;
    logic [11:0] addr = 12'h000;
    logic [3:0]  lines = 4'd0;
    logic [7:0]  x = 8'd0;
    logic [7:0]  y = 8'd0;
    logic        busy;
    logic        collision;
    logic        mem_read;
    logic [11:0] mem_read_idx;
    logic [7:0]  mem_read_byte = 8'h00;
    logic        mem_read_ack = 1'b0;
    logic        mem_write;
    logic [11:0] mem_write_idx;
    logic [7:0]  mem_write_byte;

    logic [7:0]  mem [0:4095];
    logic [11:0] w_addr[$];
    logic [7:0]  w_data[$];
    int          rd_count = 0;
    logic        overlap = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gpu_blit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .draw           (draw),
        .wrap           (wrap),
        .addr           (addr),
        .lines          (lines),
        .x              (x),
        .y              (y),
        .busy           (busy),
        .collision      (collision),
        .mem_read       (mem_read),
        .mem_read_idx   (mem_read_idx),
        .mem_read_byte  (mem_read_byte),
        .mem_read_ack   (mem_read_ack),
        .mem_write      (mem_write),
        .mem_write_idx  (mem_write_idx),
        .mem_write_byte (mem_write_byte)
    );

    // Memory model: acknowledges a read the cycle after it is requested.
    always @(posedge clk) begin
        if (mem_read && mem_write) overlap = 1'b1;
        if (mem_read && !mem_read_ack) begin
            mem_read_ack  <= 1'b1;
            mem_read_byte <= mem[mem_read_idx];
            rd_count++;
        end else begin
            mem_read_ack <= 1'b0;
        end
        if (mem_write) begin
            mem[mem_write_idx] = mem_write_byte;
            w_addr.push_back(mem_write_idx);
            w_data.push_back(mem_write_byte);
        end
    end

    task automatic clear_screen();
        for (int i = 12'h100; i < 12'h200; i++) mem[i] = 8'h00;
        w_addr.delete();
        w_data.delete();
        rd_count = 0;
    endtask

    task automatic do_draw(input logic [7:0] dx, input logic [7:0] dy, input logic [3:0] dl,
                           input logic dw, output int busy_cycles);
        @(negedge clk);
        x = dx; y = dy; lines = dl; wrap = dw; addr = 12'h200; draw = 1'b1;
        @(negedge clk);
        draw = 1'b0;
        busy_cycles = 0;
        while (busy && busy_cycles < 200) begin
            busy_cycles++;
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++;
        if (collision !== 1'b0) begin errors++; $display("FAIL reset_collision: got %b expected 0", collision); end
        checks++;
        if ({mem_read, mem_write, mem_read_idx, mem_write_idx, mem_write_byte} !== 34'd0) begin
            errors++;
            $display("FAIL reset_mem_outputs: got rd=%b wr=%b ridx=%h widx=%h wb=%h expected all 0",
                     mem_read, mem_write, mem_read_idx, mem_write_idx, mem_write_byte);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_aligned();
        int bc;
        clear_screen();
        mem[12'h200] = 8'hF0;
        do_draw(8'd0, 8'd0, 4'd1, 1'b1, bc);
        checks++;
        if (w_addr.size() !== 1 || w_addr[0] !== 12'h100 || w_data[0] !== 8'hF0) begin
            errors++;
            $display("FAIL aligned_writes: got n=%0d a0=%h d0=%h expected n=1 100=F0", w_addr.size(), w_addr[0], w_data[0]);
        end
        checks++;
        if (collision !== 1'b0) begin errors++; $display("FAIL aligned_collision: got %b expected 0", collision); end
        checks++;
        if (bc !== 5) begin errors++; $display("FAIL aligned_busy: got %0d cycles expected 5", bc); end
    endtask

    task automatic test_shift();
        int bc;
        clear_screen();
        mem[12'h200] = 8'hFF;
        do_draw(8'd4, 8'd1, 4'd1, 1'b1, bc);
        checks++;
        if (w_addr.size() !== 2 || w_addr[0] !== 12'h108 || w_data[0] !== 8'h0F
            || w_addr[1] !== 12'h109 || w_data[1] !== 8'hF0) begin
            errors++;
            $display("FAIL shift_writes: got n=%0d %h=%h %h=%h expected 108=0F 109=F0",
                     w_addr.size(), w_addr[0], w_data[0], w_addr[1], w_data[1]);
        end
        checks++;
        if (bc !== 8) begin errors++; $display("FAIL shift_busy: got %0d cycles expected 8", bc); end
    endtask

    task automatic test_edge_x();
        int bc;
        clear_screen();
        mem[12'h200] = 8'hFF;
        do_draw(8'd60, 8'd0, 4'd1, 1'b1, bc);
        checks++;
        if (w_addr.size() !== 2 || w_addr[0] !== 12'h107 || w_data[0] !== 8'h0F
            || w_addr[1] !== 12'h100 || w_data[1] !== 8'hF0) begin
            errors++;
            $display("FAIL wrap_x_writes: got n=%0d %h=%h %h=%h expected 107=0F 100=F0",
                     w_addr.size(), w_addr[0], w_data[0], w_addr[1], w_data[1]);
        end
        clear_screen();
        do_draw(8'd60, 8'd0, 4'd1, 1'b0, bc);
        checks++;
        if (w_addr.size() !== 1 || w_addr[0] !== 12'h107 || w_data[0] !== 8'h0F) begin
            errors++;
            $display("FAIL clip_x_writes: got n=%0d %h=%h expected n=1 107=0F", w_addr.size(), w_addr[0], w_data[0]);
        end
        checks++;
        if (bc !== 5) begin errors++; $display("FAIL clip_x_busy: got %0d cycles expected 5", bc); end
    endtask

    task automatic test_edge_y();
        int bc;
        clear_screen();
        mem[12'h200] = 8'h80;
        mem[12'h201] = 8'h01;
        do_draw(8'd0, 8'd31, 4'd2, 1'b1, bc);
        checks++;
        if (w_addr.size() !== 2 || w_addr[0] !== 12'h1F8 || w_data[0] !== 8'h80
            || w_addr[1] !== 12'h100 || w_data[1] !== 8'h01) begin
            errors++;
            $display("FAIL wrap_y_writes: got n=%0d %h=%h %h=%h expected 1F8=80 100=01",
                     w_addr.size(), w_addr[0], w_data[0], w_addr[1], w_data[1]);
        end
        checks++;
        if (bc !== 10) begin errors++; $display("FAIL wrap_y_busy: got %0d cycles expected 10", bc); end
        clear_screen();
        do_draw(8'd0, 8'd31, 4'd2, 1'b0, bc);
        checks++;
        if (w_addr.size() !== 1 || w_addr[0] !== 12'h1F8 || w_data[0] !== 8'h80) begin
            errors++;
            $display("FAIL clip_y_writes: got n=%0d %h=%h expected n=1 1F8=80", w_addr.size(), w_addr[0], w_data[0]);
        end
        checks++;
        if (bc !== 5) begin errors++; $display("FAIL clip_y_busy: got %0d cycles expected 5", bc); end
    endtask

    task automatic test_collision();
        int bc;
        clear_screen();
        mem[12'h200] = 8'hF0;
        do_draw(8'd0, 8'd0, 4'd1, 1'b1, bc);
        checks++;
        if (collision !== 1'b0) begin errors++; $display("FAIL first_draw_collision: got %b expected 0", collision); end
        do_draw(8'd0, 8'd0, 4'd1, 1'b1, bc);
        checks++;
        if (mem[12'h100] !== 8'h00) begin errors++; $display("FAIL erase_byte: got %h expected 00", mem[12'h100]); end
        checks++;
        if (collision !== 1'b1) begin errors++; $display("FAIL erase_collision: got %b expected 1", collision); end
        w_addr.delete();
        w_data.delete();
        rd_count = 0;
        do_draw(8'd0, 8'd0, 4'd0, 1'b1, bc);
        checks++;
        if (collision !== 1'b0) begin errors++; $display("FAIL zero_lines_collision: got %b expected 0", collision); end
        checks++;
        if (rd_count !== 0 || w_addr.size() !== 0 || bc !== 0) begin
            errors++;
            $display("FAIL zero_lines_traffic: got reads=%0d writes=%0d busy=%0d expected 0 0 0", rd_count, w_addr.size(), bc);
        end
    endtask

    task automatic test_reset_mid_draw();
        int bc;
        int guard;
        clear_screen();
        mem[12'h200] = 8'hFF;
        @(negedge clk);
        x = 8'd4; y = 8'd0; lines = 4'd1; wrap = 1'b1; addr = 12'h200; draw = 1'b1;
        @(negedge clk);
        draw = 1'b0;
        guard = 0;
        while (!(mem_read && mem_read_idx == 12'h101) && guard < 50) begin
            guard++;
            @(negedge clk);
        end
        checks++;
        if (guard >= 50) begin errors++; $display("FAIL reach_load_r: got timeout expected read of 101"); end
        rst_n = 1'b0;
        w_addr.delete();
        w_data.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy: got %b expected 0", busy); end
        checks++;
        if (w_addr.size() !== 0) begin errors++; $display("FAIL mid_reset_writes: got %0d writes expected 0", w_addr.size()); end
        mem[12'h200] = 8'hC0;
        do_draw(8'd200, 8'd0, 4'd1, 1'b1, bc);
        checks++;
        if (w_addr.size() !== 1 || w_addr[0] !== 12'h101 || w_data[0] !== 8'hC0) begin
            errors++;
            $display("FAIL x_modulo_writes: got n=%0d %h=%h expected n=1 101=C0", w_addr.size(), w_addr[0], w_data[0]);
        end
        checks++;
        if (bc !== 5) begin errors++; $display("FAIL x_modulo_busy: got %0d cycles expected 5", bc); end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        test_reset();
        test_aligned();
        test_shift();
        test_edge_x();
        test_edge_y();
        test_collision();
        test_reset_mid_draw();
        checks++;
        if (overlap !== 1'b0) begin errors++; $display("FAIL rd_wr_overlap: got %b expected 0", overlap); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
